// File: rtl/trace_capture_sequencer.sv
// Single-shot trace capture controller: arm, trigger, delay, capture window.
// Optional armed timeout is built when TRACE_SEQ_TIMEOUT_EN is defined.
module trace_capture_sequencer #(
  parameter int pDELAY_WIDTH = 20,
  parameter int pLEN_WIDTH = 24
`ifdef TRACE_SEQ_TIMEOUT_EN
  ,
  parameter int pTIMEOUT_WIDTH = 32
`endif
) (
  input  logic                    trace_clk,
  input  logic                    reset,
  input  logic                    I_arm,
  input  logic [1:0]              I_trig_src,
  input  logic                    I_target_trig,
  input  logic                    I_match_hit,
  input  logic                    I_synchronized,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pLEN_WIDTH-1:0]   I_capture_len,
  input  logic [7:0]              I_pulse_width,
  input  logic                    I_fifo_full,
`ifdef TRACE_SEQ_TIMEOUT_EN
  input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
  output logic                    O_timeout,
`endif
  output logic                    O_armed,
  output logic                    O_capturing,
  output logic                    O_trig_out,
  output logic                    O_done,
  output logic                    O_overflow,
  output logic [2:0]              O_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [pDELAY_WIDTH-1:0] DLY_ONE =
    {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE =
    {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_d;

  logic [2:0] tgt_sync;
  logic       tgt_evt;
  logic       arm_q;
  logic       sel_evt;
  logic       arm_rise;
  logic       take_trig;
  logic       cap_entry;

  logic [pDELAY_WIDTH-1:0] dly_q;
  logic [pDELAY_WIDTH-1:0] dly_cnt;
  logic [pLEN_WIDTH-1:0]   len_q;
  logic [pLEN_WIDTH-1:0]   len_cnt;
  logic [7:0]              pw_q;
  logic [7:0]              pw_src;
  logic [7:0]              pulse_cnt;
  logic [7:0]              pulse_d;

  logic done_q, done_d;
  logic ovf_q, ovf_d;
  logic armed_q, cap_q, trig_q;

`ifdef TRACE_SEQ_TIMEOUT_EN
  localparam logic [pTIMEOUT_WIDTH-1:0] TO_ONE =
    {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  logic [pTIMEOUT_WIDTH-1:0] to_cnt;
  logic to_q, to_d;
  logic to_hit;
  assign to_hit = (I_timeout != '0) && (to_cnt >= I_timeout);
`endif

  assign arm_rise  = I_arm & ~arm_q;
  assign take_trig = (state == ARMED) & I_arm & I_synchronized & sel_evt;
  assign cap_entry = (state_d == CAPTURE) && (state != CAPTURE);
  assign pw_src    = (state == ARMED) ? I_pulse_width : pw_q;

  // Target pin: two-flop synchronizer, then registered rising-edge pulse
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      tgt_sync <= '0;
      tgt_evt  <= 1'b0;
    end else begin
      tgt_sync <= {tgt_sync[1:0], I_target_trig};
      tgt_evt  <= tgt_sync[1] & ~tgt_sync[2];
    end
  end

  // Select the trigger event source
  always_comb begin
    sel_evt = 1'b0;
    unique case (I_trig_src)
      2'd0: sel_evt = tgt_evt;
      2'd1: sel_evt = I_match_hit;
      2'd2: sel_evt = 1'b1;
      2'd3: sel_evt = tgt_evt | I_match_hit;
    endcase
  end

  // State register
  always_ff @(posedge trace_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and sticky status; disarm outranks everything else
  always_comb begin
    state_d = state;
    done_d  = done_q;
    ovf_d   = ovf_q;
`ifdef TRACE_SEQ_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state)
      IDLE: begin
        if (arm_rise) begin
          state_d = ARMED;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
`ifdef TRACE_SEQ_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      ARMED: begin
        if (!I_arm) state_d = IDLE;
        else if (take_trig)
          state_d = (I_delay == '0) ? CAPTURE : DELAY;
`ifdef TRACE_SEQ_TIMEOUT_EN
        else if (to_hit) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
`endif
      end
      DELAY: begin
        if (!I_arm) state_d = IDLE;
        else if (dly_cnt == dly_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!I_arm) state_d = IDLE;
        else if (I_fifo_full) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = 1'b1;
        end else if (len_q != '0 && len_cnt == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (!I_arm) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse counter runs on its own; it only reloads once expired
  always_comb begin
    pulse_d = pulse_cnt;
    if (pulse_cnt != 8'd0) pulse_d = pulse_cnt - 8'd1;
    else if (cap_entry)    pulse_d = pw_src;
  end

  // Config latches and saturating counters
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      arm_q     <= 1'b0;
      dly_q     <= '0;
      len_q     <= '0;
      pw_q      <= '0;
      dly_cnt   <= '0;
      len_cnt   <= '0;
      pulse_cnt <= '0;
    end else begin
      arm_q     <= I_arm;
      pulse_cnt <= pulse_d;
      if (take_trig) begin
        dly_q <= I_delay;
        len_q <= I_capture_len;
        pw_q  <= I_pulse_width;
      end
      if (state_d == DELAY && state != DELAY)
        dly_cnt <= DLY_ONE;
      else if (state == DELAY && dly_cnt != '1)
        dly_cnt <= dly_cnt + DLY_ONE;
      if (cap_entry)
        len_cnt <= LEN_ONE;
      else if (state == CAPTURE && len_cnt != '1)
        len_cnt <= len_cnt + LEN_ONE;
    end
  end

`ifdef TRACE_SEQ_TIMEOUT_EN
  // Armed-cycle counter; first ARMED cycle reads 1
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_q <= to_d;
      if (state == IDLE && arm_rise)
        to_cnt <= TO_ONE;
      else if (state == ARMED && to_cnt != '1)
        to_cnt <= to_cnt + TO_ONE;
    end
  end
  assign O_timeout = to_q;
`endif

  // Registered outputs
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      cap_q   <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      armed_q <= (state_d == ARMED) || (state_d == DELAY);
      cap_q   <= (state_d == CAPTURE);
      trig_q  <= (pulse_d != 8'd0);
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign O_armed     = armed_q;
  assign O_capturing = cap_q;
  assign O_trig_out  = trig_q;
  assign O_done      = done_q;
  assign O_overflow  = ovf_q;
  assign O_state     = state;

endmodule

// File: tb/tb_trace_capture_sequencer.sv
// Randomized bench for trace_capture_sequencer.
// Expected outputs come from per-scenario event-time arithmetic.
module tb_trace_capture_sequencer;

  localparam int DW = 20;
  localparam int LW = 24;

  logic          trace_clk = 1'b0;
  logic          reset;
  logic          I_arm;
  logic [1:0]    I_trig_src;
  logic          I_target_trig;
  logic          I_match_hit;
  logic          I_synchronized;
  logic [DW-1:0] I_delay;
  logic [LW-1:0] I_capture_len;
  logic [7:0]    I_pulse_width;
  logic          I_fifo_full;
  logic          O_armed;
  logic          O_capturing;
  logic          O_trig_out;
  logic          O_done;
  logic          O_overflow;
  logic [2:0]    O_state;
`ifdef TRACE_SEQ_TIMEOUT_EN
  logic [31:0]   I_timeout;
  logic          O_timeout;
`endif

  trace_capture_sequencer #(
    .pDELAY_WIDTH(DW),
    .pLEN_WIDTH(LW)
  ) dut (
    .trace_clk(trace_clk),
    .reset(reset),
    .I_arm(I_arm),
    .I_trig_src(I_trig_src),
    .I_target_trig(I_target_trig),
    .I_match_hit(I_match_hit),
    .I_synchronized(I_synchronized),
    .I_delay(I_delay),
    .I_capture_len(I_capture_len),
    .I_pulse_width(I_pulse_width),
    .I_fifo_full(I_fifo_full),
`ifdef TRACE_SEQ_TIMEOUT_EN
    .I_timeout(I_timeout),
    .O_timeout(O_timeout),
`endif
    .O_armed(O_armed),
    .O_capturing(O_capturing),
    .O_trig_out(O_trig_out),
    .O_done(O_done),
    .O_overflow(O_overflow),
    .O_state(O_state)
  );

  always #5 trace_clk = ~trace_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scenario description, in edges counted from the arm edge (edge 0)
  int src, dly, len, pw, s_sync, ppin;
  int t_trig, cs, f_full, g_dis, e_end, oc, n_last;

  function automatic int exp_state(int k);
    if (k >= g_dis)     return 0;
    else if (k < t_trig) return 1;
    else if (k < cs)    return 2;
    else if (k < e_end) return 3;
    else                return 4;
  endfunction

  function automatic int exp_trig(int k);
    return (g_dis > cs && k >= cs && k < cs + pw) ? 1 : 0;
  endfunction

  task automatic check_all(input string pfx, input int k);
    int st;
    st = exp_state(k);
    chk({pfx, " state"}, 32'(O_state), st);
    chk({pfx, " capturing"}, 32'(O_capturing), (st == 3) ? 1 : 0);
    chk({pfx, " armed"}, 32'(O_armed), (st == 1 || st == 2) ? 1 : 0);
    chk({pfx, " trig_out"}, 32'(O_trig_out), exp_trig(k));
    chk({pfx, " done"}, 32'(O_done), (oc != 0 && k >= e_end) ? 1 : 0);
    chk({pfx, " overflow"}, 32'(O_overflow), (oc == 2 && k >= e_end) ? 1 : 0);
  endtask

  task automatic idle_inputs();
    I_arm = 1'b0;
    I_trig_src = 2'd0;
    I_target_trig = 1'b0;
    I_match_hit = 1'b0;
    I_synchronized = 1'b0;
    I_delay = '0;
    I_capture_len = '0;
    I_pulse_width = '0;
    I_fifo_full = 1'b0;
`ifdef TRACE_SEQ_TIMEOUT_EN
    I_timeout = '0;
`endif
  endtask

  task automatic gap(input int n);
    idle_inputs();
    repeat (n) @(negedge trace_clk);
  endtask

  task automatic run_scenario(input int id);
    dly = $urandom_range(0, 12);
    len = $urandom_range(0, 10);
    pw  = $urandom_range(0, 10);
    src = $urandom_range(0, 3);
    s_sync = $urandom_range(1, 4);
    ppin = 0;
    if (src == 0) begin
      ppin = $urandom_range(1, 4);
      t_trig = ppin + 3;
      s_sync = 0;
    end else if (src == 2) begin
      t_trig = s_sync;
    end else begin
      t_trig = s_sync + $urandom_range(0, 4);
    end
    cs = t_trig + dly;
    f_full = -1;
    if (len == 0 || $urandom_range(0, 1) == 1)
      f_full = cs + 1 + $urandom_range(0, (len == 0) ? 20 : len + 2);
    n_last = cs + len + 25;
    g_dis = n_last;
    if ($urandom_range(0, 3) == 0)
      g_dis = $urandom_range(1, cs + len + 3);
    // Earliest ending event wins; ties go disarm, then FIFO full
    e_end = g_dis;
    oc = 0;
    if (f_full >= 0 && f_full < e_end) begin
      e_end = f_full;
      oc = 2;
    end
    if (len > 0 && cs + len < e_end) begin
      e_end = cs + len;
      oc = 1;
    end
    for (int k = 0; k <= n_last + 2; k++) begin
      I_arm = (k < g_dis);
      I_trig_src = 2'(src);
      I_synchronized = (k >= s_sync);
      I_fifo_full = (k == f_full);
      if (src == 1 || src == 3)
        I_match_hit = (k == t_trig) || (k == t_trig + 2) ||
                      (k < s_sync && $urandom_range(0, 1) == 1);
      else
        I_match_hit = 1'($urandom_range(0, 1));
      if (src == 0)
        I_target_trig = (k >= ppin && k < ppin + 2) ||
                        (k >= cs + 3 && k < n_last);
      else if (src == 3)
        I_target_trig = 1'b0;
      else
        I_target_trig = 1'($urandom_range(0, 1));
      if (k <= t_trig) begin
        I_delay = DW'(dly);
        I_capture_len = LW'(len);
        I_pulse_width = 8'(pw);
      end else begin
        I_delay = DW'($urandom);
        I_capture_len = LW'($urandom);
        I_pulse_width = 8'($urandom);
      end
      @(posedge trace_clk);
      @(negedge trace_clk);
      check_all($sformatf("s%0d src%0d k%0d", id, src, k), k);
    end
    gap(12);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge trace_clk);
    chk("rst state", 32'(O_state), 0);
    chk("rst capturing", 32'(O_capturing), 0);
    chk("rst trig_out", 32'(O_trig_out), 0);
    chk("rst armed", 32'(O_armed), 0);
    chk("rst done", 32'(O_done), 0);
    chk("rst overflow", 32'(O_overflow), 0);
    reset = 1'b0;
    gap(6);

    for (int i = 0; i < 60; i++) run_scenario(i);

    // Reset in the middle of a capture with a long trig pulse
    I_arm = 1'b1;
    I_trig_src = 2'd2;
    I_synchronized = 1'b1;
    I_pulse_width = 8'd8;
    for (int k = 0; k < 4; k++) begin
      @(posedge trace_clk);
      @(negedge trace_clk);
    end
    chk("pre-rst capturing", 32'(O_capturing), 1);
    chk("pre-rst trig_out", 32'(O_trig_out), 1);
    reset = 1'b1;
    I_arm = 1'b0;
    @(posedge trace_clk);
    @(negedge trace_clk);
    chk("midrst capturing", 32'(O_capturing), 0);
    chk("midrst trig_out", 32'(O_trig_out), 0);
    chk("midrst state", 32'(O_state), 0);
    chk("midrst armed", 32'(O_armed), 0);
    reset = 1'b0;
    gap(6);

`ifdef TRACE_SEQ_TIMEOUT_EN
    // Armed timeout with no trigger ever qualified
    I_timeout = 32'd100;
    I_trig_src = 2'd1;
    I_arm = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(posedge trace_clk);
      @(negedge trace_clk);
      chk($sformatf("to k%0d capturing", k), 32'(O_capturing), 0);
      if (k == 99) chk("to k99 state", 32'(O_state), 1);
    end
    chk("to state", 32'(O_state), 4);
    chk("to timeout", 32'(O_timeout), 1);
    chk("to done", 32'(O_done), 0);
    gap(4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
